ro_measure_ctrl: RTL and testbench
==================================

Name: ro_measure_ctrl

Overview:
Sequences one ring-oscillator frequency-difference measurement on the shared 16-bit up/down counter: clears it, opens a programmable gate window, and steers RO-A pulses to up and RO-B pulses to down. When the window closes it waits out the counter's one-cycle update latency, captures the result and flags signed overflow. It sits between the synchronized RO pulse sources and the counter, and feeds the host-readout logic.

Parameters:
CNT_W, 16, counter width; result is two's-complement CNT_W bits.
WIN_W, 24, width of the gate-window length in clk cycles.

Ports:
clk  in  1  system clock, all logic on rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  level; sampled in IDLE only; begins a measurement.
cont  in  1  continuous mode; sampled in DONE.
abort  in  1  synchronous; forces IDLE from any state, no result update.
window_len  in  WIN_W  gate length in cycles; latched on start; 0 treated as 1.
ro_a_pulse  in  1  single-cycle pulse, already synchronized to clk (test RO).
ro_b_pulse  in  1  single-cycle pulse, already synchronized to clk (reference RO).
cnt_val  in  CNT_W  current counter output.
cnt_clr  out  1  active-high synchronous clear to counter.
up_in  out  1  counter increment request.
down_in  out  1  counter decrement request.
busy  out  1  high in every state except IDLE.
result  out  CNT_W  last captured cnt_val, held until next capture.
result_valid  out  1  one-cycle pulse when result updates.
ovf  out  1  sticky signed overflow for the measurement that produced result.

Behaviour:
- Reset (reset=0, async) forces: state=IDLE, result=0, result_valid=0, ovf=0, win_cnt=0, ovf_acc=0. cnt_clr=up_in=down_in=busy=0.
- States: IDLE, CLEAR, COUNT, DRAIN, DONE. The encoding is free.
- IDLE -> CLEAR when start=1. On that edge: latch win_len_q = (window_len==0) ? 1 : window_len; clear ovf_acc.
- CLEAR: cnt_clr=1 for exactly one cycle. On exit: win_cnt=win_len_q-1. Next state is COUNT.
- COUNT: up_in=ro_a_pulse, down_in=ro_b_pulse, combinationally gated by state. Both may be 1 together; the counter holds on 11.
  - win_cnt decrements each cycle. COUNT lasts exactly win_len_q cycles, then goes to DRAIN.
  - Outside COUNT, up_in=down_in=0 always.
- Overflow check in COUNT: set ovf_acc if (up_in & ~down_in & cnt_val==0x7FFF) or (down_in & ~up_in & cnt_val==0x8000). The raw counter wraps; the controller does not saturate.
- DRAIN: one cycle; the counter's last COUNT update is visible on cnt_val.
  - On the exiting edge: result<=cnt_val, ovf<=ovf_acc, result_valid<=1.
- DONE: result_valid=1 for this single cycle.
  - If cont=1: go to CLEAR and reload win_cnt from win_len_q; window_len is not re-sampled.
  - Otherwise go to IDLE.
- Measurement latency from start edge to result_valid: win_len_q+3 cycles (CLEAR 1, COUNT N, DRAIN 1, DONE).
- abort=1 has priority over all transitions. Next state is IDLE; result and ovf are unchanged; no result_valid; cnt_clr is not issued.
- start is ignored while busy.
- window_len changes mid-measurement have no effect.
- win_cnt never underflows: COUNT exits on win_cnt==0.

Decomposition:
- Shared package ro_meas_pkg holds:
  - state enum (IDLE, CLEAR, COUNT, DRAIN, DONE);
  - localparams CNT_MAX_POS=0x7FFF and CNT_MAX_NEG=0x8000, derived from CNT_W.
- One natural sub-module: ro_gate_timer. It is the loadable WIN_W down-counter with load, enable and zero-flag, reused for other gated measurements.
- The FSM, steering and overflow logic stay in ro_measure_ctrl.
- The bench instantiates ro_measure_ctrl with the existing up/down counter. The counter's active-high reset is driven by cnt_clr OR'd with ~reset.

Test Plan:
- Reset asserted mid-COUNT -> all outputs 0 immediately (asynchronous); IDLE after release; next start works normally.
- window_len=10, ro_a pulse every cycle, ro_b none -> result_valid at cycle 13 after start, result=10, ovf=0.
- window_len=100, ro_a every 2nd cycle, ro_b every 4th, both coincident on multiples of 4 -> result=25 (50 up, 25 down, 25 coincident holds).
- window_len=0, ro_a constant 1 -> treated as 1; result=1; COUNT lasted 1 cycle.
- window_len=0x9000, ro_a every cycle -> ovf=1, result=0x9000 (raw wrapped value).
- cont=1, window_len=8, ro_b every cycle, abort raised in the 3rd window's COUNT -> two result_valid pulses (result=0xFFF8 each), then IDLE with result held at 0xFFF8 and no third pulse.

Source files
------------

// File: rtl/ro_meas_pkg.sv
// Shared types and constants for the ring-oscillator measurement controller.
package ro_meas_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int WIN_W_DEF = 24;

  // Signed extremes of the default-width up/down counter.
  localparam logic [CNT_W_DEF-1:0] CNT_MAX_POS = {1'b0, {(CNT_W_DEF-1){1'b1}}};
  localparam logic [CNT_W_DEF-1:0] CNT_MAX_NEG = {1'b1, {(CNT_W_DEF-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_COUNT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/ro_measure_ctrl_if.sv
// Control, pulse-steering and readout signals between the measurement
// controller (slave) and its surroundings: host, RO sync and counter (master).
interface ro_measure_ctrl_if #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 24
);
  logic             start;
  logic             cont;
  logic             abort;
  logic [WIN_W-1:0] window_len;
  logic             ro_a_pulse;
  logic             ro_b_pulse;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_clr;
  logic             up_in;
  logic             down_in;
  logic             busy;
  logic [CNT_W-1:0] result;
  logic             result_valid;
  logic             ovf;

  modport master (
    output start, cont, abort, window_len, ro_a_pulse, ro_b_pulse, cnt_val,
    input  cnt_clr, up_in, down_in, busy, result, result_valid, ovf
  );

  modport slave (
    input  start, cont, abort, window_len, ro_a_pulse, ro_b_pulse, cnt_val,
    output cnt_clr, up_in, down_in, busy, result, result_valid, ovf
  );
endinterface

// File: rtl/ro_gate_timer.sv
// Loadable down-counter for gate windows; holds at zero and flags it.
module ro_gate_timer #(
  parameter int WIN_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIN_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [WIN_W-1:0] cnt_q;

  // Load has priority over counting; never decrements below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - WIN_W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ro_measure_ctrl.sv
// Sequences one RO frequency-difference measurement on a shared up/down
// counter: clear, gated count window, drain, capture with overflow flag.
module ro_measure_ctrl
  import ro_meas_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  ro_measure_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] MAX_POS = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] MAX_NEG = {1'b1, {(CNT_W-1){1'b0}}};

  state_e           state_q, state_d;
  logic [WIN_W-1:0] win_len_q;
  logic             ovf_acc_q;
  logic [CNT_W-1:0] result_q;
  logic             ovf_q;
  logic             result_valid_q;

  logic             win_zero;
  logic             in_count;
  logic             up_d, down_d;
  logic             ovf_hit;
  logic             enter_clear;

  ro_gate_timer #(.WIN_W(WIN_W)) u_gate_timer (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (state_q == ST_CLEAR),
    .load_val_i (win_len_q - WIN_W'(1)),
    .en_i       (in_count),
    .zero_o     (win_zero)
  );

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_COUNT;
      ST_COUNT: if (win_zero) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = bus.cont ? ST_CLEAR : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (bus.abort) state_d = ST_IDLE;
  end

  // Pulse steering and overflow detection on the pre-update counter value.
  always_comb begin
    in_count    = (state_q == ST_COUNT);
    up_d        = in_count & bus.ro_a_pulse;
    down_d      = in_count & bus.ro_b_pulse;
    ovf_hit     = (up_d & ~down_d & (bus.cnt_val == MAX_POS)) |
                  (down_d & ~up_d & (bus.cnt_val == MAX_NEG));
    enter_clear = (state_d == ST_CLEAR) && (state_q != ST_CLEAR);
  end

  // State, window latch and per-measurement overflow accumulator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      win_len_q <= WIN_W'(1);
      ovf_acc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && (state_d == ST_CLEAR)) begin
        win_len_q <= (bus.window_len == '0) ? WIN_W'(1) : bus.window_len;
      end
      if (enter_clear) begin
        ovf_acc_q <= 1'b0;
      end else if (ovf_hit) begin
        ovf_acc_q <= 1'b1;
      end
    end
  end

  // Result capture when DRAIN completes; the counter has settled by then.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q       <= '0;
      ovf_q          <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      if ((state_q == ST_DRAIN) && !bus.abort) begin
        result_q       <= bus.cnt_val;
        ovf_q          <= ovf_acc_q;
        result_valid_q <= 1'b1;
      end
    end
  end

  assign bus.cnt_clr      = (state_q == ST_CLEAR);
  assign bus.up_in        = up_d;
  assign bus.down_in      = down_d;
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.ovf          = ovf_q;

endmodule

// File: tb/tb_ro_measure_ctrl.sv
// Bench for ro_measure_ctrl with a behavioural 16-bit up/down counter.
module tb_ro_measure_ctrl;
  import ro_meas_pkg::*;

  localparam int CW = 16;
  localparam int WW = 24;

  typedef struct {
    logic [WW-1:0] win;
    int unsigned   a_mode;
    int unsigned   b_mode;
    logic [CW-1:0] exp_res;
    logic          exp_ovf;
    int unsigned   exp_lat;
  } vec_t;

  logic clk;
  logic rst_n;
  logic [CW-1:0] cnt_q;
  logic cnt_rst;

  int unsigned checks;
  int unsigned failures;
  int unsigned a_mode_r;
  int unsigned b_mode_r;
  int unsigned kcyc;

  ro_measure_ctrl_if #(.CNT_W(CW), .WIN_W(WW)) bus ();

  ro_measure_ctrl #(.CNT_W(CW), .WIN_W(WW)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Up/down counter with active-high async reset; holds when both requests set.
  assign cnt_rst = bus.cnt_clr | ~rst_n;
  always_ff @(posedge clk or posedge cnt_rst) begin
    if (cnt_rst) cnt_q <= '0;
    else if (bus.up_in && !bus.down_in) cnt_q <= cnt_q + 16'd1;
    else if (bus.down_in && !bus.up_in) cnt_q <= cnt_q - 16'd1;
  end
  assign bus.cnt_val = cnt_q;

  function automatic logic mode_hit(input int unsigned m, input int unsigned k);
    case (m)
      1:       return 1'b1;
      2:       return (k % 2) == 0;
      3:       return (k % 4) == 0;
      default: return 1'b0;
    endcase
  endfunction

  // RO pulse sources, updated away from the active edge.
  initial begin
    kcyc = 0;
    bus.ro_a_pulse = 1'b0;
    bus.ro_b_pulse = 1'b0;
    forever begin
      @(negedge clk);
      kcyc++;
      bus.ro_a_pulse = mode_hit(a_mode_r, kcyc);
      bus.ro_b_pulse = mode_hit(b_mode_r, kcyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns edges from the start-sampling edge
  // to the first edge after which result_valid is seen high.
  task automatic run_meas(input logic [WW-1:0] win, input int unsigned am,
                          input int unsigned bm, output int unsigned lat);
    int unsigned budget;
    budget = int'(win) + 40;
    a_mode_r = am;
    b_mode_r = bm;
    bus.window_len = win;
    bus.start = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        bus.start = 1'b0;
        bus.window_len = 24'd3;
      end
    end while (!bus.result_valid && lat < budget);
  endtask

  vec_t vecs[6];

  initial begin
    int unsigned lat;
    int unsigned n;
    int unsigned extra;

    checks = 0;
    failures = 0;
    a_mode_r = 0;
    b_mode_r = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.cont = 1'b0;
    bus.abort = 1'b0;
    bus.window_len = '0;

    vecs[0] = '{win: 24'd10,     a_mode: 1, b_mode: 0, exp_res: 16'd10,   exp_ovf: 1'b0, exp_lat: 13};
    vecs[1] = '{win: 24'd100,    a_mode: 2, b_mode: 3, exp_res: 16'd25,   exp_ovf: 1'b0, exp_lat: 103};
    vecs[2] = '{win: 24'd0,      a_mode: 1, b_mode: 0, exp_res: 16'd1,    exp_ovf: 1'b0, exp_lat: 4};
    vecs[3] = '{win: 24'h009000, a_mode: 1, b_mode: 0, exp_res: 16'h9000, exp_ovf: 1'b1, exp_lat: 32'h9003};
    vecs[4] = '{win: 24'd8,      a_mode: 0, b_mode: 1, exp_res: 16'hFFF8, exp_ovf: 1'b0, exp_lat: 11};
    vecs[5] = '{win: 24'd5,      a_mode: 1, b_mode: 1, exp_res: 16'd0,    exp_ovf: 1'b0, exp_lat: 8};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_result", 32'(bus.result), 32'd0);
    chk("reset_valid_ovf", {30'd0, bus.result_valid, bus.ovf}, 32'd0);
    chk("reset_steer", {29'd0, bus.cnt_clr, bus.up_in, bus.down_in}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      run_meas(vecs[i].win, vecs[i].a_mode, vecs[i].b_mode, lat);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_result", i), 32'(bus.result), 32'(vecs[i].exp_res));
      chk($sformatf("v%0d_ovf", i), 32'(bus.ovf), 32'(vecs[i].exp_ovf));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_idle_after", i), {30'd0, bus.busy, bus.result_valid}, 32'd0);
    end

    // Continuous mode: two full windows, abort during the third COUNT.
    a_mode_r = 0;
    b_mode_r = 1;
    bus.cont = 1'b1;
    bus.window_len = 24'd8;
    bus.start = 1'b1;
    n = 0;
    for (int e = 0; e < 100 && n < 2; e++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.result_valid) begin
        n++;
        chk($sformatf("cont_result_%0d", n), 32'(bus.result), 32'hFFF8);
      end
    end
    chk("cont_pulses", n, 32'd2);
    repeat (3) @(posedge clk);
    #1;
    chk("cont_in_count", {30'd0, bus.busy, bus.down_in}, 32'd3);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    bus.cont = 1'b0;
    chk("abort_idle", 32'(bus.busy), 32'd0);
    extra = 0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk);
      #1;
      if (bus.result_valid || bus.cnt_clr || bus.busy) extra++;
    end
    chk("abort_quiet", extra, 32'd0);
    chk("abort_result_held", {15'd0, bus.ovf, bus.result}, 32'h0000FFF8);

    // Asynchronous reset in the middle of a COUNT window.
    a_mode_r = 1;
    b_mode_r = 0;
    bus.window_len = 24'd50;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_reset_counting", {30'd0, bus.busy, bus.up_in}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy_up", {30'd0, bus.busy, bus.up_in}, 32'd0);
    chk("async_rst_result", {15'd0, bus.ovf, bus.result}, 32'd0);
    chk("async_rst_valid_clr", {30'd0, bus.result_valid, bus.cnt_clr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(bus.busy), 32'd0);
    run_meas(24'd10, 1, 0, lat);
    chk("post_rst_latency", lat, 32'd13);
    chk("post_rst_result", {15'd0, bus.ovf, bus.result}, 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
